// File: rtl/ariane_rst_seq_pkg.sv
// Shared types for the FPGA reset sequencer: FSM states, reset-cause codes and
// the width of the single shared phase counter.
package ariane_rst_seq_pkg;

  typedef enum logic [2:0] {
    StLock,
    StMem,
    StPeriph,
    StRun,
    StNdm,
    StSw
  } rst_state_e;

  typedef enum logic [1:0] {
    CausePor = 2'd0,
    CausePll = 2'd1,
    CauseNdm = 2'd2,
    CauseSw  = 2'd3
  } rst_cause_e;

  // One counter serves every timed phase, so it is sized for the longest one.
  function automatic int unsigned cnt_width(input int unsigned lock_filter,
                                            input int unsigned mem_to_periph,
                                            input int unsigned periph_to_core,
                                            input int unsigned sw_hold);
    int unsigned max_val;
    max_val = lock_filter;
    if (mem_to_periph > max_val) max_val = mem_to_periph;
    if (periph_to_core > max_val) max_val = periph_to_core;
    if (sw_hold > max_val) max_val = sw_hold;
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/ariane_rst_seq.sv
// Reset sequencer: waits for a filtered PLL lock, releases memory, peripheral
// and core resets in order, and re-sequences on lock loss, ndmreset or SW request.
module ariane_rst_seq
  import ariane_rst_seq_pkg::*;
#(
  parameter int unsigned LOCK_FILTER    = 16,
  parameter int unsigned MEM_TO_PERIPH  = 8,
  parameter int unsigned PERIPH_TO_CORE = 8,
  parameter int unsigned SW_HOLD        = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pll_locked_i,
  input  logic       ndmreset_req_i,
  input  logic       sw_rst_req_i,
  output logic       rst_mem_no,
  output logic       rst_periph_no,
  output logic       rst_core_no,
  output logic       busy_o,
  output logic [1:0] rst_cause_o
);

  localparam int unsigned CntW = cnt_width(LOCK_FILTER, MEM_TO_PERIPH, PERIPH_TO_CORE, SW_HOLD);

  localparam logic [CntW-1:0] LockLast   = CntW'(LOCK_FILTER - 1);
  localparam logic [CntW-1:0] MemLast    = CntW'(MEM_TO_PERIPH - 1);
  localparam logic [CntW-1:0] PeriphLast = CntW'(PERIPH_TO_CORE - 1);
  localparam logic [CntW-1:0] SwLast     = CntW'(SW_HOLD - 1);

  rst_state_e      state_q, state_d;
  rst_cause_e      cause_q, cause_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            mem_q, mem_d;
  logic            periph_q, periph_d;
  logic            core_q, core_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    periph_d = periph_q;
    core_d   = core_q;
    busy_d   = busy_q;

    // Lock loss overrides every other event once the sequence has started.
    if (state_q != StLock && !pll_locked_i) begin
      mem_d    = 1'b0;
      periph_d = 1'b0;
      core_d   = 1'b0;
      busy_d   = 1'b1;
      cause_d  = CausePll;
      cnt_d    = '0;
      state_d  = StLock;
    end else begin
      unique case (state_q)
        StLock: begin
          if (!pll_locked_i) begin
            cnt_d = '0;
          end else if (cnt_q == LockLast) begin
            cnt_d   = '0;
            mem_d   = 1'b1;
            state_d = StMem;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StMem: begin
          if (cnt_q == MemLast) begin
            cnt_d    = '0;
            periph_d = 1'b1;
            state_d  = StPeriph;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StPeriph: begin
          if (cnt_q == PeriphLast) begin
            cnt_d   = '0;
            core_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StRun;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        StRun: begin
          if (ndmreset_req_i) begin
            core_d   = 1'b0;
            periph_d = 1'b0;
            busy_d   = 1'b1;
            cause_d  = CauseNdm;
            cnt_d    = '0;
            state_d  = StNdm;
          end else if (sw_rst_req_i) begin
            core_d   = 1'b0;
            periph_d = 1'b0;
            busy_d   = 1'b1;
            cause_d  = CauseSw;
            cnt_d    = '0;
            state_d  = StSw;
          end
        end
        StNdm: begin
          if (!ndmreset_req_i) begin
            cnt_d    = '0;
            periph_d = 1'b1;
            state_d  = StPeriph;
          end
        end
        StSw: begin
          if (cnt_q == SwLast) begin
            cnt_d    = '0;
            periph_d = 1'b1;
            state_d  = StPeriph;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        default: begin
          mem_d    = 1'b0;
          periph_d = 1'b0;
          core_d   = 1'b0;
          busy_d   = 1'b1;
          cnt_d    = '0;
          state_d  = StLock;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StLock;
      cause_q  <= CausePor;
      cnt_q    <= '0;
      mem_q    <= 1'b0;
      periph_q <= 1'b0;
      core_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
      periph_q <= periph_d;
      core_q   <= core_d;
      busy_q   <= busy_d;
    end
  end

  assign rst_mem_no    = mem_q;
  assign rst_periph_no = periph_q;
  assign rst_core_no   = core_q;
  assign busy_o        = busy_q;
  assign rst_cause_o   = cause_q;

  // A domain may only leave reset once everything it depends on is out of reset.
  a_release_order : assert property (@(posedge clk_i)
      (!rst_core_no || rst_periph_no) && (!rst_periph_no || rst_mem_no));

endmodule

// File: tb/tb_ariane_rst_seq.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a deadline-based model of the release schedule.
module tb_ariane_rst_seq;

  localparam int LF = 16;
  localparam int MP = 8;
  localparam int PC = 8;
  localparam int SH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       ndm_req = 1'b0;
  logic       sw_req = 1'b0;
  logic       rst_mem_n;
  logic       rst_periph_n;
  logic       rst_core_n;
  logic       busy;
  logic [1:0] cause;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ariane_rst_seq #(
    .LOCK_FILTER   (LF),
    .MEM_TO_PERIPH (MP),
    .PERIPH_TO_CORE(PC),
    .SW_HOLD       (SH)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pll_locked_i  (pll_locked),
    .ndmreset_req_i(ndm_req),
    .sw_rst_req_i  (sw_req),
    .rst_mem_no    (rst_mem_n),
    .rst_periph_no (rst_periph_n),
    .rst_core_no   (rst_core_n),
    .busy_o        (busy),
    .rst_cause_o   (cause)
  );

  // Model: outputs plus absolute edge numbers at which pending releases fire.
  int   edge_n = 0;
  int   lock_run = 0;
  int   t_per = -1;
  int   t_core = -1;
  bit   ndm_hold = 0;
  bit   m_valid = 0;
  bit   m_mem = 0, m_per = 0, m_core = 0;
  int   m_cause = 0;

  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      m_valid = 1; m_mem = 0; m_per = 0; m_core = 0; m_cause = 0;
      lock_run = 0; t_per = -1; t_core = -1; ndm_hold = 0;
    end else if (!m_mem) begin
      lock_run = pll_locked ? lock_run + 1 : 0;
      if (lock_run == LF) begin
        m_mem = 1; lock_run = 0;
        t_per = edge_n + MP; t_core = edge_n + MP + PC;
      end
    end else if (!pll_locked) begin
      m_mem = 0; m_per = 0; m_core = 0; m_cause = 1;
      lock_run = 0; t_per = -1; t_core = -1; ndm_hold = 0;
    end else if (ndm_hold) begin
      if (!ndm_req) begin
        ndm_hold = 0; m_per = 1; t_core = edge_n + PC;
      end
    end else if (m_core) begin
      if (ndm_req) begin
        m_core = 0; m_per = 0; m_cause = 2; ndm_hold = 1;
      end else if (sw_req) begin
        m_core = 0; m_per = 0; m_cause = 3;
        t_per = edge_n + SH; t_core = edge_n + SH + PC;
      end
    end else begin
      if (edge_n == t_per) m_per = 1;
      if (edge_n == t_core) m_core = 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Advance one cycle; compare every output against the model at the negedge.
  task automatic tick();
    @(negedge clk);
    if (m_valid) begin
      check("mem", int'(rst_mem_n), int'(m_mem));
      check("periph", int'(rst_periph_n), int'(m_per));
      check("core", int'(rst_core_n), int'(m_core));
      check("busy", int'(busy), int'(!m_core));
      check("cause", int'(cause), m_cause);
    end
  endtask

  task automatic step(input int k);
    repeat (k) tick();
  endtask

  task automatic pin_outs(input string name, input int mem, input int per, input int core,
                          input int cs);
    check({name, "_mem"}, int'(rst_mem_n), mem);
    check({name, "_per"}, int'(rst_periph_n), per);
    check({name, "_core"}, int'(rst_core_n), core);
    check({name, "_busy"}, int'(busy), (core == 0) ? 1 : 0);
    check({name, "_cause"}, int'(cause), cs);
  endtask

  initial begin
    step(3);
    pin_outs("por_reset", 0, 0, 0, 0);

    // POR sequence
    rst_n = 1'b1; pll_locked = 1'b1;
    step(15); check("por_mem_early", int'(rst_mem_n), 0);
    step(1);  check("por_mem_rise", int'(rst_mem_n), 1);
    check("model_mem_rise", int'(m_mem), 1);
    step(7);  check("por_per_early", int'(rst_periph_n), 0);
    step(1);  check("por_per_rise", int'(rst_periph_n), 1);
    step(7);  check("por_core_early", int'(rst_core_n), 0);
    step(1);  pin_outs("por_run", 1, 1, 1, 0);
    check("model_core_rise", int'(m_core), 1);

    // Lock glitch while filtering
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    step(9); pll_locked = 1'b0; step(1); pll_locked = 1'b1;
    step(15); check("glitch_mem_early", int'(rst_mem_n), 0);
    step(1);  check("glitch_mem_rise", int'(rst_mem_n), 1);
    step(16); pin_outs("glitch_run", 1, 1, 1, 0);

    // Lock loss in run
    pll_locked = 1'b0; step(1); pin_outs("loss", 0, 0, 0, 1);
    step(2); pll_locked = 1'b1;
    step(16); check("relock_mem", int'(rst_mem_n), 1);
    step(8);  check("relock_per", int'(rst_periph_n), 1);
    step(8);  pin_outs("relock_run", 1, 1, 1, 1);

    // ndmreset held for 20 cycles
    ndm_req = 1'b1; step(1); pin_outs("ndm_assert", 1, 0, 0, 2);
    step(19); check("ndm_hold_per", int'(rst_periph_n), 0);
    ndm_req = 1'b0; step(1); pin_outs("ndm_release", 1, 1, 0, 2);
    step(7); check("ndm_core_early", int'(rst_core_n), 0);
    step(1); pin_outs("ndm_run", 1, 1, 1, 2);

    // ndmreset and sw together: ndm wins
    ndm_req = 1'b1; sw_req = 1'b1; step(1); pin_outs("both", 1, 0, 0, 2);
    ndm_req = 1'b0; sw_req = 1'b0; step(1); check("both_per", int'(rst_periph_n), 1);
    step(8); check("both_core", int'(rst_core_n), 1);

    // Lone sw pulse
    sw_req = 1'b1; step(1); pin_outs("sw_assert", 1, 0, 0, 3);
    sw_req = 1'b0; step(3); check("sw_per_early", int'(rst_periph_n), 0);
    step(1); check("sw_per_rise", int'(rst_periph_n), 1);
    step(7); check("sw_core_early", int'(rst_core_n), 0);
    step(1); pin_outs("sw_run", 1, 1, 1, 3);

    // Board reset while in S_PERIPH
    sw_req = 1'b1; step(1); sw_req = 1'b0; step(5);
    rst_n = 1'b0; step(1); pin_outs("rst_in_periph", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 5000; i++) begin
      pll_locked = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 99) < 3) ndm_req = ~ndm_req;
      sw_req = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 1499) != 0);
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
